xmas_merge_arb: RTL and testbench

Round-robin merge arbiter sharing one downstream irdy/trdy channel among N upstream requesters, for the xMAS-style queue networks. Each upstream channel offers a word with `in_irdy`; the arbiter grants one requester per cycle, captures its word in a one-entry output buffer, and presents it downstream on `out_irdy`/`out_data`. It sits in front of a queue chain, with its output driving a queue's write side, when several producers feed one queue.

---
 rtl/xmas_merge_arb.sv | 77 +++++++
 tb/tb_xmas_merge_arb.sv | 126 ++++++++++++
 2 files changed

// File: rtl/xmas_merge_arb.sv
// xmas_merge_arb: round-robin merge of N irdy/trdy requesters into a one-entry output buffer.
// Optional macro XMAS_MERGE_FIXED_PRIO_EN selects lowest-index fixed priority instead.
module xmas_merge_arb #(
    parameter int N   = 4,
    parameter int W   = 32,
    parameter int IDW = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     in_irdy,
    output logic [N-1:0]     in_trdy,
    input  logic [N*W-1:0]   in_data,
    output logic             out_irdy,
    input  logic             out_trdy,
    output logic [W-1:0]     out_data,
    output logic [IDW-1:0]   out_src
);
    typedef enum logic {EMPTY, FULL} state_t;
    state_t         state_q, state_d;
    logic [W-1:0]   data_q, data_d;
    logic [IDW-1:0] src_q, src_d, ptr_q, ptr_d, gnt;
    logic [2*N-1:0] dbl;
    logic [N-1:0]   rot;
    logic           found, space, load, drain;
    assign dbl = {in_irdy, in_irdy};
    // Requests rotated so that bit 0 is the requester the pointer favours.
    always_comb begin
        rot   = dbl[int'(ptr_q) +: N];
        gnt   = '0;
        found = 1'b0;
`ifdef XMAS_MERGE_FIXED_PRIO_EN
        for (int k = N - 1; k >= 0; k--) begin
            if (in_irdy[k]) begin
                gnt   = IDW'(k);
                found = 1'b1;
            end
        end
`else
        for (int k = N - 1; k >= 0; k--) begin
            if (rot[k]) begin
                gnt   = IDW'((int'(ptr_q) + k) % N);
                found = 1'b1;
            end
        end
`endif
    end
    assign space    = (state_q == EMPTY) | out_trdy;
    assign load     = found & space;
    assign drain    = (state_q == FULL) & out_trdy;
    assign in_trdy  = (load & ~rst) ? (N'(1) << gnt) : '0;
    assign out_irdy = (state_q == FULL);
    assign out_data = data_q;
    assign out_src  = src_q;
    always_comb begin
        state_d = load ? FULL : (drain ? EMPTY : state_q);
        data_d  = load ? in_data[int'(gnt)*W +: W] : data_q;
        src_d   = load ? gnt : src_q;
`ifdef XMAS_MERGE_FIXED_PRIO_EN
        ptr_d   = '0;
`else
        ptr_d   = load ? IDW'((int'(gnt) + 1) % N) : ptr_q;
`endif
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= EMPTY;
            data_q  <= '0;
            src_q   <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            src_q   <= src_d;
            ptr_q   <= ptr_d;
        end
    end
endmodule

// File: tb/tb_xmas_merge_arb.sv
// tb_xmas_merge_arb: scoreboard bench with a queue-level reference model of the merge arbiter.
module tb_xmas_merge_arb;
    localparam int N = 4;
    localparam int W = 32;
    localparam int IDW = 2;
    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   in_irdy = '0;
    logic [N-1:0]   in_trdy;
    logic [N*W-1:0] in_data = '0;
    logic           out_irdy;
    logic           out_trdy = 1'b0;
    logic [W-1:0]   out_data;
    logic [IDW-1:0] out_src;
    typedef struct {logic [W-1:0] d; int s;} item_t;
    item_t sb[$];
    int n_cmp = 0;
    int n_bad = 0;
    int m_ptr = 0;
    bit m_full = 0;
    logic [W-1:0] m_last = '0;
    xmas_merge_arb #(.N(N), .W(W)) dut (
        .clk(clk), .rst(rst), .in_irdy(in_irdy), .in_trdy(in_trdy), .in_data(in_data),
        .out_irdy(out_irdy), .out_trdy(out_trdy), .out_data(out_data), .out_src(out_src)
    );
    always #5 clk = ~clk;
    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask
    function automatic int winner(input logic [N-1:0] r);
`ifdef XMAS_MERGE_FIXED_PRIO_EN
        for (int i = 0; i < N; i++) if (r[i]) return i;
`else
        for (int k = 0; k < N; k++) if (r[(m_ptr + k) % N]) return (m_ptr + k) % N;
`endif
        return -1;
    endfunction
    // One cycle: drive at posedge+1, check and advance the model at negedge.
    task automatic step(input logic [N-1:0] r, input logic t, input bit rnd);
        int g;
        bit sp;
        logic [N-1:0] e;
        in_irdy  = r;
        out_trdy = t;
        for (int i = 0; i < N; i++) in_data[i*W +: W] = rnd ? $urandom : 32'hA0 + i;
        @(negedge clk);
        g  = winner(r);
        sp = !m_full || t;
        e  = (g >= 0 && sp) ? N'(1) << g : '0;
        chk("in_trdy", 64'(in_trdy), 64'(e));
        chk("out_irdy", 64'(out_irdy), 64'(m_full));
        if (m_full && t) m_full = 0;
        if (g >= 0 && sp) begin
            sb.push_back('{in_data[g*W +: W], g});
            m_last = in_data[g*W +: W];
            m_full = 1;
            m_ptr  = (g + 1) % N;
        end
        @(posedge clk);
        #1;
    endtask
    always @(negedge clk) begin
        if (!rst && out_irdy && out_trdy) begin
            if (sb.size() == 0) chk("sb_underflow", 64'(out_irdy), 64'(0));
            else begin
                item_t it;
                it = sb.pop_front();
                chk("out_data", 64'(out_data), 64'(it.d));
                chk("out_src", 64'(out_src), 64'(it.s));
            end
        end
    end
    initial begin
        #3;
        chk("rst_out_irdy", 64'(out_irdy), 64'(0));
        chk("rst_out_data", 64'(out_data), 64'(0));
        chk("rst_in_trdy", 64'(in_trdy), 64'(0));
        @(posedge clk);
        #1 rst = 1'b0;
        // All requesters active with free downstream: strict rotation, no bubbles.
        for (int c = 0; c < 9; c++) step(4'b1111, 1'b1, 0);
        // Backpressure: buffer full, downstream stalled, then resumes.
        step(4'b0000, 1'b1, 0);
        step(4'b0001, 1'b0, 0);
        for (int c = 0; c < 3; c++) begin
            step(4'b1111, 1'b0, 0);
            chk("stall_data", 64'(out_data), 64'(m_last));
        end
        step(4'b1111, 1'b1, 0);
        // Sparse requests and pointer wrap.
        step(4'b0100, 1'b1, 0);
        step(4'b0010, 1'b1, 0);
        step(4'b1000, 1'b1, 0);
        step(4'b1001, 1'b1, 0);
        // Drain to empty; the last word stays visible on out_data.
        for (int c = 0; c < 3; c++) step(4'b0000, 1'b1, 0);
        chk("drain_data", 64'(out_data), 64'(m_last));
`ifdef XMAS_MERGE_FIXED_PRIO_EN
        for (int c = 0; c < 6; c++) step(4'b1011, 1'b1, 0);
`endif
        // Asynchronous reset while a word is buffered.
        step(4'b0100, 1'b0, 0);
        in_irdy = 4'b1111;
        #2 rst = 1'b1;
        #1;
        chk("arst_out_irdy", 64'(out_irdy), 64'(0));
        chk("arst_out_data", 64'(out_data), 64'(0));
        chk("arst_out_src", 64'(out_src), 64'(0));
        chk("arst_in_trdy", 64'(in_trdy), 64'(0));
        sb.delete();
        m_full = 0;
        m_ptr  = 0;
        @(posedge clk);
        #1 rst = 1'b0;
        step(4'b0110, 1'b1, 0);
        for (int c = 0; c < 400; c++) step(N'($urandom), $urandom_range(0, 3) != 0, 1);
        for (int c = 0; c < 3; c++) step(4'b0000, 1'b1, 1);
        chk("sb_left", 64'(sb.size()), 64'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
